div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter SIZE, default 5: counter and length width in bits.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port req  input  NREQ: per-requester request; bit i is level-held until done[i] or voluntary drop.
REQ-006 Port len  input  NREQ*SIZE: terminal count per requester; slice i is len[i*SIZE +: SIZE], sampled only at grant.
REQ-007 Port cep  input  1: count enable; the counter advances only when cep is high.
REQ-008 Port grant  output  NREQ: one-hot owner of the shared counter, or all zero.
REQ-009 Port busy  output  1: high while state is RUN or DONE.
REQ-010 Port count  output  SIZE: current shared-counter value.
REQ-011 Port tc  output  1: combinational terminal-count strobe.
REQ-012 Port done  output  NREQ: one-cycle completion pulse to the owner.

Function
REQ-013 FSM states: IDLE, RUN and DONE.
REQ-014 IDLE with req nonzero: next edge picks the winner round-robin, searching from (last+1) mod NREQ upward.
REQ-015 On that edge: grant is set one-hot to the winner, term latches len[winner], count clears to 0, and the FSM enters RUN.
REQ-016 IDLE with req zero: the FSM holds; grant=0 and count=0.
REQ-017 RUN with cep=1 and count!=term: count increments by 1.
REQ-018 RUN with cep=0: count holds.
REQ-019 RUN with cep=1 and count==term: count clears to 0 and the FSM enters DONE.
REQ-020 A grant completes after exactly term+1 cep-high cycles (term=0 means 1 cycle).
REQ-021 tc = (state==RUN) and cep and (count==term); it is low otherwise.
REQ-022 DONE: done[owner]=1 for exactly one cycle and grant is held; the next edge goes to IDLE, clears grant and sets last=owner.
REQ-023 No re-arbitration occurs in DONE; the earliest next grant is one cycle after DONE (one IDLE cycle).
REQ-024 If req[owner] drops during RUN, the next edge aborts: the FSM enters IDLE, grant=0, count=0, last=owner, and no done pulse is issued.
REQ-025 If req[owner] drops on the same edge as completion, completion takes priority (DONE is entered and done pulses).
REQ-026 Changes to len or to req of non-owners during RUN have no effect.
REQ-027 count never exceeds term; count arithmetic is SIZE bits with no carry out.

Reset
REQ-028 When rst=1 at an edge: the FSM enters IDLE, grant=0, count=0, term=0, last=NREQ-1 (so requester 0 wins first), and done=0.
REQ-029 rst overrides every other input, including mid-RUN and in DONE; no done pulse is issued for an interrupted grant.
REQ-030 tc=0 and busy=0 in the cycle after reset.

Structure
REQ-031 Package div_sched_pkg holds the state enum (IDLE, RUN, DONE) and the default SIZE and NREQ constants.
REQ-032 Round-robin selection is implemented in sub-module rr_arbiter (inputs req and last; outputs a one-hot winner and a valid flag), instantiated once.
REQ-033 Counter, term register and FSM reside in div_sched itself.

Verification
REQ-034 Test 1: after reset, req=0001, len0=19, cep=1 constant -> grant=0001 on the next cycle, tc high on the 20th RUN cycle, done=0001 one cycle later, then grant=0.
REQ-035 Test 2: req=1111 held with all len=0 -> grants issued in the order 0001, 0010, 0100, 1000, 0001; each grant lasts 2 cycles, with 1 IDLE cycle between grants.
REQ-036 Test 3: len0=3 with cep toggling 1,0,1,0,... -> count sequence 0,1,1,2,2,3; done issued after 4 cep-high cycles.
REQ-037 Test 4: req0 dropped while count=2 with len0=5 -> IDLE on the next edge, no done pulse; a pending req1 is granted next.
REQ-038 Test 5: rst asserted mid-RUN at count=7 -> next cycle count=0, grant=0, done=0; requester 0 wins first after release.
REQ-039 Test 6: len0=31 (SIZE=5) -> count reaches 31, tc asserts, count wraps to 0 and done fires; no overflow occurs.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared state encoding and default sizing for the shared-counter scheduler.
package div_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_SIZE = 5;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from the requester after last.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [LW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);
  logic [LW-1:0] idx;
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last_i) + k) % NREQ);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/div_sched.sv
// div_sched: grants a shared SIZE-bit counter to one requester at a time and
// counts its cep-high cycles up to the latched terminal value.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int SIZE = DEF_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] len,
  input  logic                 cep,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [SIZE-1:0]      count,
  output logic                 tc,
  output logic [NREQ-1:0]      done
);
  localparam int LW = $clog2(NREQ);
  state_t          state_q;
  logic [NREQ-1:0] grant_q, done_q, win;
  logic [SIZE-1:0] count_q, term_q;
  logic [LW-1:0]   last_q, owner_q, win_idx;
  logic            win_vld, at_term;
  rr_arbiter #(.NREQ(NREQ), .LW(LW)) u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (win),
    .valid_o(win_vld)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) win_idx = win[i] ? LW'(i) : win_idx;
  end
  assign at_term = count_q == term_q;
  assign tc      = state_q == RUN && cep && at_term;
  assign busy    = state_q != IDLE;
  assign grant   = grant_q;
  assign count   = count_q;
  assign done    = done_q;
  // Completion is tested before the request-drop abort so a same-edge drop still finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      term_q  <= '0;
      owner_q <= '0;
      last_q  <= LW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: if (win_vld) begin
          state_q <= RUN;
          grant_q <= win;
          term_q  <= len[win_idx*SIZE +: SIZE];
          owner_q <= win_idx;
          count_q <= '0;
        end
        RUN: if (cep && at_term) begin
          state_q <= DONE;
          count_q <= '0;
          done_q  <= grant_q;
        end else if (!req[owner_q]) begin
          state_q <= IDLE;
          grant_q <= '0;
          count_q <= '0;
          last_q  <= owner_q;
        end else if (cep) begin
          count_q <= count_q + SIZE'(1);
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          done_q  <= '0;
          last_q  <= owner_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed scenarios plus randomized traffic checked against a
// transaction-level model (owner, cep-high cycles remaining, done phase).
module tb_div_sched;
  localparam int NREQ = 4;
  localparam int SIZE = 5;
  logic                 clk, rst, cep, tc, busy;
  logic [NREQ-1:0]      req, grant, done;
  logic [NREQ*SIZE-1:0] len;
  logic [SIZE-1:0]      count;
  int checks = 0, failures = 0;
  bit armed = 0;
  int m_owner = -1, m_left = 0, m_term = 0, m_last = NREQ - 1, mc;
  bit m_done = 0;
  int t3[7] = '{0, 1, 1, 2, 2, 3, 3};

  div_sched #(.NREQ(NREQ), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .cep(cep),
    .grant(grant), .busy(busy), .count(count), .tc(tc), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // Model: a grant owns the counter for term+1 cep-high cycles, then one done cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_done = 0; m_last = NREQ - 1; m_left = 0; m_term = 0;
    end else if (m_done) begin
      m_last = m_owner; m_owner = -1; m_done = 0;
    end else if (m_owner >= 0) begin
      if (cep && m_left == 1) begin
        m_done = 1; m_left = 0;
      end else if (!req[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end else if (cep) m_left--;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        mc = (m_last + k) % NREQ;
        if (m_owner < 0 && req[mc]) begin
          m_owner = mc;
          m_term  = int'(len[mc*SIZE +: SIZE]);
          m_left  = m_term + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("grant", int'(grant), m_owner >= 0 ? (1 << m_owner) : 0);
      check("count", int'(count), (m_owner >= 0 && !m_done) ? m_term + 1 - m_left : 0);
      check("busy", int'(busy), int'(m_owner >= 0));
      check("done", int'(done), m_done ? (1 << m_owner) : 0);
      check("tc", int'(tc), int'(m_owner >= 0 && !m_done && cep && m_left == 1));
    end
  end

  initial begin
    rst = 1; req = '0; len = '0; cep = 0;
    tick();
    armed = 1;
    // Test 1: single requester, term 19
    do_reset();
    req = 4'b0001; len = '0; len[0 +: SIZE] = 5'd19; cep = 1;
    @(negedge clk);
    check("t1_rst_grant", int'(grant), 0);
    check("t1_rst_busy", int'(busy), 0);
    check("t1_rst_tc", int'(tc), 0);
    check("t1_rst_count", int'(count), 0);
    tick();
    @(negedge clk);
    check("t1_grant", int'(grant), 1);
    check("t1_count0", int'(count), 0);
    repeat (19) tick();
    @(negedge clk);
    check("t1_tc", int'(tc), 1);
    check("t1_count19", int'(count), 19);
    tick();
    req = '0;
    @(negedge clk);
    check("t1_done", int'(done), 1);
    check("t1_grant_held", int'(grant), 1);
    tick();
    @(negedge clk);
    check("t1_grant_clr", int'(grant), 0);
    check("t1_done_clr", int'(done), 0);
    // Test 2: all requesting, len 0
    do_reset();
    req = 4'hf; len = '0; cep = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      @(negedge clk);
      check("t2_grant", int'(grant), (i % 3 == 2) ? 0 : (1 << ((i / 3) % 4)));
    end
    req = '0;
    // Test 3: cep toggling, term 3
    do_reset();
    req = 4'b0001; len = '0; len[0 +: SIZE] = 5'd3;
    for (int i = 0; i < 7; i++) begin
      tick();
      cep = (i % 2 == 0);
      @(negedge clk);
      check("t3_count", int'(count), t3[i]);
    end
    check("t3_tc", int'(tc), 1);
    tick();
    req = '0; cep = 1;
    @(negedge clk);
    check("t3_done", int'(done), 1);
    // Test 4: owner drops mid-run
    do_reset();
    req = 4'b0011; len = '0; len[0 +: SIZE] = 5'd5; len[SIZE +: SIZE] = 5'd2; cep = 1;
    repeat (3) tick();
    req = 4'b0010;
    @(negedge clk);
    check("t4_count2", int'(count), 2);
    tick();
    @(negedge clk);
    check("t4_abort_grant", int'(grant), 0);
    check("t4_abort_done", int'(done), 0);
    check("t4_abort_busy", int'(busy), 0);
    tick();
    @(negedge clk);
    check("t4_next_grant", int'(grant), 2);
    repeat (4) tick();
    req = '0;
    tick();
    // Test 5: reset mid-run
    do_reset();
    req = 4'b0011; len = '0; len[0 +: SIZE] = 5'd20; len[SIZE +: SIZE] = 5'd1; cep = 1;
    repeat (8) tick();
    rst = 1;
    @(negedge clk);
    check("t5_count7", int'(count), 7);
    tick();
    rst = 0;
    @(negedge clk);
    check("t5_count", int'(count), 0);
    check("t5_grant", int'(grant), 0);
    check("t5_done", int'(done), 0);
    check("t5_busy", int'(busy), 0);
    tick();
    @(negedge clk);
    check("t5_first", int'(grant), 1);
    // Test 6: full-range term
    do_reset();
    req = 4'b0001; len = '0; len[0 +: SIZE] = 5'd31; cep = 1;
    repeat (32) tick();
    @(negedge clk);
    check("t6_count31", int'(count), 31);
    check("t6_tc", int'(tc), 1);
    tick();
    req = '0;
    @(negedge clk);
    check("t6_done", int'(done), 1);
    check("t6_wrap", int'(count), 0);
    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      cep = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 3) == 0)
          len[i*SIZE +: SIZE] = ($urandom_range(0, 7) == 0) ? SIZE'($urandom_range(0, 31))
                                                            : SIZE'($urandom_range(0, 3));
      end
    end
    tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
